// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch (I) and load/store (D) with a grant FSM.
// Define ARB_RR_EN for round-robin on simultaneous requests; otherwise D has fixed priority.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_ack,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_wEn,
  input  logic [1:0]        d_size,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_rdata,
  output logic              m_req,
  output logic              m_wEn,
  output logic [1:0]        m_size,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic              m_ack,
  input  logic [DATA_W-1:0] m_rdata,
  output logic              bus_err,
  output logic              busy
);

  localparam logic [1:0] SizeHword = 2'b01;
  localparam logic [1:0] SizeWord  = 2'b10;

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e            state_q, state_d;
  logic              grant_is_d_q, grant_is_d_d;
  logic [7:0]        wdog_q, wdog_d, wdog_inc;
  logic              m_req_q, m_req_d, m_wen_q, m_wen_d;
  logic [1:0]        m_size_q, m_size_d;
  logic [ADDR_W-1:0] m_addr_q, m_addr_d;
  logic [DATA_W-1:0] m_wdata_q, m_wdata_d;
  logic              i_ack_q, i_ack_d, d_ack_q, d_ack_d, bus_err_q, bus_err_d;
  logic [DATA_W-1:0] i_rdata_q, i_rdata_d, d_rdata_q, d_rdata_d;
  logic              pick_d, d_illegal;
`ifdef ARB_RR_EN
  logic              last_is_d_q, last_is_d_d;
`endif

  assign d_illegal = (d_size == 2'b11) ||
                     ((d_size == SizeHword) && d_addr[0]) ||
                     ((d_size == SizeWord) && (d_addr[1:0] != 2'b00));

`ifdef ARB_RR_EN
  assign pick_d = d_req && (!i_req || !last_is_d_q);
`else
  assign pick_d = d_req;
`endif

  // Saturating increment so the count never wraps back below TIMEOUT.
  assign wdog_inc = (wdog_q == 8'hFF) ? wdog_q : wdog_q + 8'd1;

  always_comb begin
    state_d      = state_q;
    grant_is_d_d = grant_is_d_q;
    wdog_d       = wdog_q;
    m_req_d      = m_req_q;
    m_wen_d      = m_wen_q;
    m_size_d     = m_size_q;
    m_addr_d     = m_addr_q;
    m_wdata_d    = m_wdata_q;
    i_rdata_d    = i_rdata_q;
    d_rdata_d    = d_rdata_q;
    i_ack_d      = 1'b0;
    d_ack_d      = 1'b0;
    bus_err_d    = 1'b0;
`ifdef ARB_RR_EN
    last_is_d_d  = last_is_d_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (i_req || d_req) begin
          grant_is_d_d = pick_d;
`ifdef ARB_RR_EN
          last_is_d_d  = pick_d;
`endif
          if (pick_d && d_illegal) begin
            d_ack_d   = 1'b1;
            d_rdata_d = '0;
            bus_err_d = 1'b1;
            state_d   = StResp;
          end else begin
            m_req_d   = 1'b1;
            m_addr_d  = pick_d ? d_addr : i_addr;
            m_wen_d   = pick_d && d_wEn;
            m_size_d  = pick_d ? d_size : SizeWord;
            m_wdata_d = pick_d ? d_wdata : '0;
            wdog_d    = 8'd0;
            state_d   = StWait;
          end
        end
      end
      StWait: begin
        if (m_ack) begin
          m_req_d = 1'b0;
          if (grant_is_d_q) begin
            d_rdata_d = m_rdata;
            d_ack_d   = 1'b1;
          end else begin
            i_rdata_d = m_rdata;
            i_ack_d   = 1'b1;
          end
          state_d = StResp;
        end else begin
          wdog_d = wdog_inc;
          // wdog_inc counts the WAIT cycle just ending, so m_req stays high TIMEOUT cycles.
          if ((TIMEOUT != 0) && ({24'd0, wdog_inc} == TIMEOUT)) begin
            m_req_d   = 1'b0;
            bus_err_d = 1'b1;
            if (grant_is_d_q) begin
              d_rdata_d = '0;
              d_ack_d   = 1'b1;
            end else begin
              i_rdata_d = '0;
              i_ack_d   = 1'b1;
            end
            state_d = StResp;
          end
        end
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q      <= StIdle;
      grant_is_d_q <= 1'b0;
      wdog_q       <= 8'd0;
      m_req_q      <= 1'b0;
      m_wen_q      <= 1'b0;
      m_size_q     <= 2'b00;
      m_addr_q     <= '0;
      m_wdata_q    <= '0;
      i_ack_q      <= 1'b0;
      d_ack_q      <= 1'b0;
      i_rdata_q    <= '0;
      d_rdata_q    <= '0;
      bus_err_q    <= 1'b0;
`ifdef ARB_RR_EN
      last_is_d_q  <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      grant_is_d_q <= grant_is_d_d;
      wdog_q       <= wdog_d;
      m_req_q      <= m_req_d;
      m_wen_q      <= m_wen_d;
      m_size_q     <= m_size_d;
      m_addr_q     <= m_addr_d;
      m_wdata_q    <= m_wdata_d;
      i_ack_q      <= i_ack_d;
      d_ack_q      <= d_ack_d;
      i_rdata_q    <= i_rdata_d;
      d_rdata_q    <= d_rdata_d;
      bus_err_q    <= bus_err_d;
`ifdef ARB_RR_EN
      last_is_d_q  <= last_is_d_d;
`endif
    end
  end

  assign m_req   = m_req_q;
  assign m_wEn   = m_wen_q;
  assign m_size  = m_size_q;
  assign m_addr  = m_addr_q;
  assign m_wdata = m_wdata_q;
  assign i_ack   = i_ack_q;
  assign d_ack   = d_ack_q;
  assign i_rdata = i_rdata_q;
  assign d_rdata = d_rdata_q;
  assign bus_err = bus_err_q;
  assign busy    = (state_q != StIdle);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter, built with TIMEOUT=4 so the watchdog can be exercised.
module tb_mem_port_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic        i_req, d_req, d_wEn, m_ack;
  logic [31:0] i_addr, d_addr, d_wdata, m_rdata;
  logic [1:0]  d_size;
  logic        i_ack, d_ack, m_req, m_wEn, bus_err, busy;
  logic [31:0] i_rdata, d_rdata, m_addr, m_wdata;
  logic [1:0]  m_size;

  int n_cmp = 0;
  int n_err = 0;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4)) dut (
    .clock(clock), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
    .d_req(d_req), .d_wEn(d_wEn), .d_size(d_size), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata),
    .m_req(m_req), .m_wEn(m_wEn), .m_size(m_size), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_ack(m_ack), .m_rdata(m_rdata),
    .bus_err(bus_err), .busy(busy)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic exp_d;
    reset = 1'b0; i_req = 1'b0; d_req = 1'b0; d_wEn = 1'b0; m_ack = 1'b0;
    i_addr = '0; d_addr = '0; d_wdata = '0; m_rdata = '0; d_size = 2'b00;
    step(); step();
    check("rst_m_req", m_req, 0);   check("rst_i_ack", i_ack, 0);
    check("rst_d_ack", d_ack, 0);   check("rst_bus_err", bus_err, 0);
    check("rst_busy", busy, 0);     check("rst_i_rdata", i_rdata, 0);
    check("rst_d_rdata", d_rdata, 0); check("rst_m_addr", m_addr, 0);
    reset = 1'b1;
    step();

    // Lone fetch, memory acks in the first m_req cycle.
    i_req = 1'b1; i_addr = 32'h100; m_ack = 1'b1; m_rdata = 32'h00A00093;
    step();
    check("t1_m_req", m_req, 1);    check("t1_m_addr", m_addr, 32'h100);
    check("t1_m_wEn", m_wEn, 0);    check("t1_m_size", m_size, 2'b10);
    check("t1_busy", busy, 1);      check("t1_i_ack_early", i_ack, 0);
    step();
    check("t1_i_ack", i_ack, 1);    check("t1_i_rdata", i_rdata, 32'h00A00093);
    check("t1_m_req_drop", m_req, 0); check("t1_bus_err", bus_err, 0);
    i_req = 1'b0; m_ack = 1'b0;
    step();
    check("t1_i_ack_pulse", i_ack, 0); check("t1_idle", busy, 0);
    check("t1_rdata_hold", i_rdata, 32'h00A00093);

    // Lone byte store, memory acks in the third m_req cycle.
    d_req = 1'b1; d_wEn = 1'b1; d_size = 2'b00; d_addr = 32'h203; d_wdata = 32'hAB;
    step();
    check("t2_m_req", m_req, 1);    check("t2_m_wEn", m_wEn, 1);
    check("t2_m_size", m_size, 0);  check("t2_m_addr", m_addr, 32'h203);
    check("t2_m_wdata", m_wdata, 32'hAB);
    step();
    check("t2_m_req_c2", m_req, 1); check("t2_d_ack_c2", d_ack, 0);
    step();
    check("t2_m_req_c3", m_req, 1);
    m_ack = 1'b1;
    step();
    check("t2_d_ack", d_ack, 1);    check("t2_bus_err", bus_err, 0);
    check("t2_m_req_drop", m_req, 0);
    d_req = 1'b0; d_wEn = 1'b0; m_ack = 1'b0;
    step();
    check("t2_d_ack_pulse", d_ack, 0); check("t2_idle", busy, 0);

    // Reset during WAIT abandons the access without an ack.
    i_req = 1'b1; i_addr = 32'h300;
    step();
    check("t3_m_req", m_req, 1);
    step();
    reset = 1'b0;
    step();
    check("t3_rst_m_req", m_req, 0); check("t3_rst_busy", busy, 0);
    check("t3_rst_i_ack", i_ack, 0);
    reset = 1'b1; m_ack = 1'b1; m_rdata = 32'h55;
    step();
    check("t3_fresh_m_req", m_req, 1); check("t3_fresh_addr", m_addr, 32'h300);
    check("t3_no_ack", i_ack, 0);
    step();
    check("t3_fresh_ack", i_ack, 1); check("t3_fresh_rdata", i_rdata, 32'h55);
    i_req = 1'b0;
    step();

    // Simultaneous I and D for four transactions; last_grant is I here.
    i_req = 1'b1; i_addr = 32'h100;
    d_req = 1'b1; d_wEn = 1'b0; d_size = 2'b10; d_addr = 32'h40;
    for (int k = 0; k < 4; k++) begin
`ifdef ARB_RR_EN
      exp_d = (k % 2 == 0);
`else
      exp_d = 1'b1;
`endif
      m_rdata = 32'h1000 + k;
      step();
      check("t4_m_req", m_req, 1);
      check("t4_m_addr", m_addr, exp_d ? 32'h40 : 32'h100);
      check("t4_m_size", m_size, 2'b10);
      step();
      check("t4_d_ack", d_ack, exp_d);
      check("t4_i_ack", i_ack, !exp_d);
      check("t4_rdata", exp_d ? d_rdata : i_rdata, 32'h1000 + k);
      step();
      check("t4_idle", busy, 0);
    end
    i_req = 1'b0; d_req = 1'b0; m_ack = 1'b0;
    step();

    // Misaligned word load: no memory access, error response.
    d_req = 1'b1; d_size = 2'b10; d_addr = 32'h102;
    step();
    check("t5_m_req", m_req, 0);    check("t5_d_ack", d_ack, 1);
    check("t5_bus_err", bus_err, 1); check("t5_d_rdata", d_rdata, 0);
    check("t5_busy", busy, 1);
    d_req = 1'b0;
    step();
    check("t5_d_ack_pulse", d_ack, 0); check("t5_err_pulse", bus_err, 0);

    // Odd halfword and reserved size are also rejected.
    d_req = 1'b1; d_size = 2'b01; d_addr = 32'h201;
    step();
    check("t5_hw_m_req", m_req, 0); check("t5_hw_err", bus_err, 1);
    d_req = 1'b0;
    step();
    d_req = 1'b1; d_size = 2'b11; d_addr = 32'h200;
    step();
    check("t5_sz3_m_req", m_req, 0); check("t5_sz3_err", bus_err, 1);
    d_req = 1'b0;
    step();

    // Watchdog: memory never acks.
    i_req = 1'b1; i_addr = 32'h400; m_rdata = 32'hDEAD;
    for (int c = 0; c < 4; c++) begin
      step();
      check("t6_m_req_held", m_req, 1);
      check("t6_no_ack", i_ack, 0);
    end
    step();
    check("t6_m_req_drop", m_req, 0); check("t6_i_ack", i_ack, 1);
    check("t6_bus_err", bus_err, 1);  check("t6_i_rdata", i_rdata, 0);
    i_req = 1'b0;
    step();
    check("t6_busy", busy, 0);        check("t6_err_pulse", bus_err, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
